// File: rtl/led_pulse_driver.sv
// Queued LED pulse driver: each request lights one active-low LED for ON_CYCLES, then holds a GAP_CYCLES dark gap.
// Optional sticky overflow flag Ovf when built with LED_PULSE_DRIVER_OVF_EN defined.
module led_pulse_driver #(
  parameter int ON_CYCLES  = 25,
  parameter int GAP_CYCLES = 5,
  parameter int DEPTH      = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Pin,
  input  logic [1:0] Sym,
  output logic [3:0] Lout,
  output logic       Busy,
  output logic       Full,
`ifdef LED_PULSE_DRIVER_OVF_EN
  output logic       Ovf,
`endif
  output logic       Done
);

  localparam int PW      = $clog2(DEPTH);
  localparam int CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sym_q, sym_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [3:0]    lout_q, lout_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          full_q, full_d;
  logic [1:0]    mem_q [DEPTH];
  logic          push, pop;

  // Full is the registered copy of the pre-edge count, so a drop ignores a same-edge pop.
  assign push = Pin && !full_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sym_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      lout_q   <= 4'b1111;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sym_q    <= sym_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      lout_q   <= lout_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst && push) begin
      mem_q[wr_ptr_q] <= Sym;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sym_d   = sym_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          sym_d   = mem_q[rd_ptr_q];
          cnt_d   = ON_LOAD;
          state_d = S_ON;
        end
      end
      S_ON: begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_LOAD;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            sym_d   = mem_q[rd_ptr_q];
            cnt_d   = ON_LOAD;
            state_d = S_ON;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    lout_d = 4'b1111;
    if (state_d == S_ON) begin
      lout_d = ~(4'b0001 << sym_d);
    end
    done_d = (state_q == S_ON) && (state_d == S_GAP);
    busy_d = (state_d != S_IDLE) || (count_d != '0);
    full_d = (count_d == CNT_FULL);
  end

  assign Lout = lout_q;
  assign Done = done_q;
  assign Busy = busy_q;
  assign Full = full_q;

`ifdef LED_PULSE_DRIVER_OVF_EN
  logic ovf_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ovf_q <= 1'b0;
    end else if (Pin && full_q) begin
      ovf_q <= 1'b1;
    end
  end

  assign Ovf = ovf_q;
`endif

endmodule
